sfp_feeder: RTL and testbench

SFP_FEEDER -- requirements
Module: sfp_feeder

---
 rtl/sfp_pkg.sv | 14 +
 rtl/sfp_fifo.sv | 68 ++++++
 rtl/sfp_feeder.sv | 108 ++++++++++
 tb/tb_sfp_feeder.sv | 351 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sfp_pkg.sv
// Shared FSM state type and default sizing for the partial-sum feeder.
// Imported by sfp_fifo and sfp_feeder.
package sfp_pkg;
  localparam int BW_DEF    = 4;
  localparam int DEPTH_DEF = 8;

  typedef enum logic [2:0] {
    IDLE,
    CLR,
    ACC,
    RELU,
    DONE
  } state_t;
endpackage

// File: rtl/sfp_fifo.sv
// Circular-buffer FIFO: a push becomes poppable on the following cycle (no bypass path).
// full/empty come from the occupancy count only; flush empties it on the next edge and drops a concurrent push.
module sfp_fifo
  import sfp_pkg::*;
#(
  parameter int bw    = BW_DEF,
  parameter int depth = DEPTH_DEF
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          flush_i,
  input  logic          push_i,
  input  logic [bw-1:0] push_dat_i,
  input  logic          pop_i,
  output logic [bw-1:0] head_dat_o,
  output logic          full_o,
  output logic          empty_o
);
  localparam int AW = (depth > 1) ? $clog2(depth) : 1;
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(depth);

  logic [bw-1:0] mem_q [depth];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          do_push;
  logic          do_pop;

  assign full_o     = (cnt_q == FULL_CNT);
  assign empty_o    = (cnt_q == '0);
  assign head_dat_o = mem_q[rd_ptr_q];
  assign do_push    = push_i && !full_o && !flush_i;
  assign do_pop     = pop_i && !empty_o && !flush_i;

  // depth is a power of two, so pointers wrap by plain overflow
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    if (flush_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      cnt_d    = '0;
    end else begin
      if (do_push) wr_ptr_d = wr_ptr_q + AW'(1);
      if (do_pop)  rd_ptr_d = rd_ptr_q + AW'(1);
      if (do_push && !do_pop)      cnt_d = cnt_q + CW'(1);
      else if (do_pop && !do_push) cnt_d = cnt_q - CW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= push_dat_i;
  end
endmodule

// File: rtl/sfp_feeder.sv
// Buffers column partial sums and sequences clear / accumulate / threshold strobes; all strobes registered.
// in_ready = FIFO not full; optional abort port under SFP_FEEDER_ABORT_EN.
module sfp_feeder
  import sfp_pkg::*;
#(
  parameter int bw    = BW_DEF,
  parameter int depth = DEPTH_DEF
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic signed [bw-1:0] in_data,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic                 start,
  input  logic [3:0]           len,
`ifdef SFP_FEEDER_ABORT_EN
  input  logic                 abort,
`endif
  output logic signed [bw-1:0] out,
  output logic                 acc,
  output logic                 relu,
  output logic                 psum_clr,
  output logic                 busy,
  output logic                 done
);
  state_t               state_q, state_d;
  logic [3:0]           rem_q, rem_d;
  logic signed [bw-1:0] out_q;
  logic                 acc_q, relu_q, psum_clr_q, done_q;
  logic                 pop;
  logic                 kill;
  logic                 fifo_full, fifo_empty;
  logic [bw-1:0]        fifo_head;

`ifdef SFP_FEEDER_ABORT_EN
  assign kill = abort;
`else
  assign kill = 1'b0;
`endif

  sfp_fifo #(.bw(bw), .depth(depth)) u_fifo (
    .clk        (clk),
    .rst_n      (reset),
    .flush_i    (kill),
    .push_i     (in_valid),
    .push_dat_i (in_data),
    .pop_i      (pop),
    .head_dat_o (fifo_head),
    .full_o     (fifo_full),
    .empty_o    (fifo_empty)
  );

  // ACC leaves only once remaining is already zero, so the last acc strobe never overlaps relu
  always_comb begin
    state_d = state_q;
    rem_d   = rem_q;
    pop     = 1'b0;
    unique case (state_q)
      IDLE: if (start) begin
        state_d = CLR;
        rem_d   = len;
      end
      CLR:  state_d = (rem_q != 4'd0) ? ACC : RELU;
      ACC:  if (rem_q == 4'd0) begin
        state_d = RELU;
      end else if (!fifo_empty) begin
        pop   = 1'b1;
        rem_d = rem_q - 4'd1;
      end
      RELU: state_d = DONE;
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (kill) begin
      state_d = IDLE;
      rem_d   = '0;
      pop     = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= IDLE;
      rem_q      <= '0;
      out_q      <= '0;
      acc_q      <= 1'b0;
      relu_q     <= 1'b0;
      psum_clr_q <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      rem_q      <= rem_d;
      acc_q      <= pop;
      if (pop) out_q <= fifo_head;
      psum_clr_q <= (state_d == CLR);
      relu_q     <= (state_d == RELU);
      done_q     <= (state_d == DONE);
    end
  end

  assign in_ready = !fifo_full;
  assign out      = out_q;
  assign acc      = acc_q;
  assign relu     = relu_q;
  assign psum_clr = psum_clr_q;
  assign done     = done_q;
  assign busy     = (state_q != IDLE);
endmodule

// File: tb/tb_sfp_feeder.sv
// Scenario bench for sfp_feeder: a model FIFO scoreboards every acc strobe, scenario tasks check strobe timing.
module tb_sfp_feeder;
  localparam int BW    = 4;
  localparam int DEPTH = 8;

  logic                 clk      = 1'b0;
  logic                 reset    = 1'b0;
  logic signed [BW-1:0] in_data  = '0;
  logic                 in_valid = 1'b0;
  logic                 start    = 1'b0;
  logic                 abort_r  = 1'b0;
  logic [3:0]           len      = '0;
  logic                 in_ready, acc, relu, psum_clr, busy, done;
  logic signed [BW-1:0] out;

  int n_tests = 0, n_fail = 0, cyc = 0;
  int done_cnt = 0, psum_cyc = -1, relu_cyc = -1, done_cyc = -1, busy_lo = 0;
  bit job_active = 1'b0;
  int acc_cycs[$];
  logic signed [BW-1:0] model[$];
  logic signed [BW-1:0] exp_v;

  sfp_feeder #(.bw(BW), .depth(DEPTH)) dut (
    .clk(clk), .reset(reset), .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .start(start), .len(len),
`ifdef SFP_FEEDER_ABORT_EN
    .abort(abort_r),
`endif
    .out(out), .acc(acc), .relu(relu), .psum_clr(psum_clr), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  // Model FIFO: accepts a push only when its own occupancy is below DEPTH
  always @(posedge clk) begin
    cyc++;
    if (reset && !abort_r && in_valid && model.size() < DEPTH) model.push_back(in_data);
  end

  always @(negedge clk) begin
    if (reset) begin
      if (acc) begin
        acc_cycs.push_back(cyc);
        n_tests++;
        if (model.size() == 0) begin
          n_fail++;
          $display("FAIL acc_unexpected cyc=%0d out=%0d (model empty)", cyc, out);
        end else begin
          exp_v = model.pop_front();
          if (out !== exp_v) begin
            n_fail++;
            $display("FAIL acc_data cyc=%0d got %0d exp %0d", cyc, out, exp_v);
          end
        end
      end
      if (acc || relu || psum_clr) begin
        n_tests++;
        if (int'(acc) + int'(relu) + int'(psum_clr) > 1) begin
          n_fail++;
          $display("FAIL strobe_excl cyc=%0d acc=%b relu=%b clr=%b exp one-hot", cyc, acc, relu, psum_clr);
        end
      end
      if (psum_clr) psum_cyc = cyc;
      if (relu) relu_cyc = cyc;
      if (done) begin
        done_cyc = cyc;
        done_cnt++;
      end
      if (job_active && !busy) busy_lo++;
    end
  end

  task automatic clear_obs();
    acc_cycs.delete();
    psum_cyc = -1;
    relu_cyc = -1;
    done_cyc = -1;
    busy_lo  = 0;
  endtask

  task automatic drive_push(input int v, output int e);
    @(posedge clk); #1;
    in_valid = 1'b1;
    in_data  = BW'(v);
    @(posedge clk); #1;
    e        = cyc;
    in_valid = 1'b0;
  endtask

  task automatic drive_start(input int l, output int s);
    @(posedge clk); #1;
    start = 1'b1;
    len   = 4'(l);
    @(posedge clk); #1;
    s     = cyc;
    start = 1'b0;
  endtask

  task automatic wait_done(input int d0, output bit ok);
    for (int i = 0; i < 64; i++) begin
      if (done_cnt != d0) break;
      @(posedge clk);
    end
    ok = (done_cnt != d0);
    job_active = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    model.delete();
    repeat (2) @(posedge clk);
    #1;
    n_tests++;
    if ({acc, relu, psum_clr, done, busy} !== 5'b0) begin
      n_fail++;
      $display("FAIL reset_strobes got %b exp 00000", {acc, relu, psum_clr, done, busy});
    end
    n_tests++;
    if (out !== '0) begin n_fail++; $display("FAIL reset_out got %0d exp 0", out); end
    n_tests++;
    if (in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready got %b exp 1", in_ready); end
    @(negedge clk) reset = 1'b1;
  endtask

  task automatic test_basic();
    int e, s, d0;
    bit ok;
    clear_obs();
    drive_push(3, e);
    drive_push(-2, e);
    drive_push(5, e);
    d0 = done_cnt;
    drive_start(3, s);
    job_active = 1'b1;
    wait_done(d0, ok);
    n_tests++;
    if (!ok) begin n_fail++; $display("FAIL basic_timeout got no done exp done"); end
    n_tests++;
    if (psum_cyc !== s) begin n_fail++; $display("FAIL basic_psum_clr got %0d exp %0d", psum_cyc, s); end
    n_tests++;
    if (acc_cycs.size() != 3 || acc_cycs[0] != s + 2 || acc_cycs[1] != s + 3 || acc_cycs[2] != s + 4) begin
      n_fail++;
      $display("FAIL basic_acc_cycles got n=%0d first=%0d exp n=3 first=%0d",
               acc_cycs.size(), (acc_cycs.size() > 0) ? acc_cycs[0] : -1, s + 2);
    end
    n_tests++;
    if (relu_cyc !== s + 5) begin n_fail++; $display("FAIL basic_relu got %0d exp %0d", relu_cyc, s + 5); end
    n_tests++;
    if (done_cyc !== s + 6) begin n_fail++; $display("FAIL basic_done got %0d exp %0d", done_cyc, s + 6); end
    n_tests++;
    if (busy_lo != 0) begin n_fail++; $display("FAIL basic_busy got %0d low cycles exp 0", busy_lo); end
  endtask

  task automatic test_stall();
    int s, p1, p2, d0;
    bit ok;
    clear_obs();
    d0 = done_cnt;
    drive_start(2, s);
    job_active = 1'b1;
    repeat (3) @(posedge clk);
    drive_push(7, p1);
    @(posedge clk);
    drive_push(-1, p2);
    wait_done(d0, ok);
    n_tests++;
    if (!ok) begin n_fail++; $display("FAIL stall_timeout got no done exp done"); end
    n_tests++;
    if (acc_cycs.size() != 2 || acc_cycs[0] != p1 + 1 || acc_cycs[1] != p2 + 1) begin
      n_fail++;
      $display("FAIL stall_acc_cycles got n=%0d first=%0d exp n=2 first=%0d second=%0d",
               acc_cycs.size(), (acc_cycs.size() > 0) ? acc_cycs[0] : -1, p1 + 1, p2 + 1);
    end
    n_tests++;
    if (done_cyc !== p2 + 3) begin n_fail++; $display("FAIL stall_done got %0d exp %0d", done_cyc, p2 + 3); end
    n_tests++;
    if (busy_lo != 0) begin n_fail++; $display("FAIL stall_busy got %0d low cycles exp 0", busy_lo); end
  endtask

  task automatic test_full();
    int fill[8] = '{1, 2, 3, 4, 5, 6, 7, -8};
    int s, d0;
    bit ok;
    clear_obs();
    @(posedge clk); #1;
    in_valid = 1'b1;
    for (int i = 0; i < 8; i++) begin
      in_data = BW'(fill[i]);
      @(posedge clk); #1;
    end
    n_tests++;
    if (in_ready !== 1'b0) begin n_fail++; $display("FAIL full_in_ready got %b exp 0", in_ready); end
    in_data = -4'sd1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    n_tests++;
    if (in_ready !== 1'b0) begin n_fail++; $display("FAIL full_ninth got in_ready=%b exp 0", in_ready); end
    d0 = done_cnt;
    drive_start(1, s);
    @(negedge clk);
    @(negedge clk);
    n_tests++;
    if (in_ready !== 1'b0) begin n_fail++; $display("FAIL full_before_pop got %b exp 0", in_ready); end
    @(negedge clk);
    n_tests++;
    if (in_ready !== 1'b1) begin n_fail++; $display("FAIL full_after_pop got %b exp 1", in_ready); end
    wait_done(d0, ok);
    n_tests++;
    if (!ok || acc_cycs.size() != 1 || acc_cycs[0] != s + 2) begin
      n_fail++;
      $display("FAIL full_one_pop got done=%b n=%0d exp done=1 n=1 at %0d", ok, acc_cycs.size(), s + 2);
    end
    clear_obs();
    d0 = done_cnt;
    drive_start(7, s);
    wait_done(d0, ok);
    n_tests++;
    if (!ok || acc_cycs.size() != 7 || in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL full_drain got done=%b n=%0d in_ready=%b exp 1 7 1", ok, acc_cycs.size(), in_ready);
    end
  endtask

  task automatic test_len0();
    int e, s, d0;
    bit ok;
    clear_obs();
    drive_push(6, e);
    drive_push(-3, e);
    d0 = done_cnt;
    drive_start(0, s);
    wait_done(d0, ok);
    n_tests++;
    if (!ok || psum_cyc !== s || relu_cyc !== s + 1 || done_cyc !== s + 2) begin
      n_fail++;
      $display("FAIL len0_seq got clr=%0d relu=%0d done=%0d exp %0d %0d %0d",
               psum_cyc, relu_cyc, done_cyc, s, s + 1, s + 2);
    end
    n_tests++;
    if (acc_cycs.size() != 0) begin n_fail++; $display("FAIL len0_acc got %0d pops exp 0", acc_cycs.size()); end
    clear_obs();
    d0 = done_cnt;
    drive_start(2, s);
    wait_done(d0, ok);
    n_tests++;
    if (!ok || acc_cycs.size() != 2) begin
      n_fail++;
      $display("FAIL len0_untouched got done=%b n=%0d exp done=1 n=2", ok, acc_cycs.size());
    end
  endtask

  task automatic test_reset_mid();
    int e, s, d0;
    bit ok;
    clear_obs();
    drive_push(2, e);
    drive_push(-5, e);
    d0 = done_cnt;
    drive_start(2, s);
    @(posedge clk); #1;
    reset = 1'b0;
    model.delete();
    #1;
    n_tests++;
    if ({acc, relu, psum_clr, done, busy} !== 5'b0 || out !== '0 || in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL rstmid_outputs got strobes=%b out=%0d in_ready=%b exp 00000 0 1",
               {acc, relu, psum_clr, done, busy}, out, in_ready);
    end
    @(negedge clk);
    @(negedge clk) reset = 1'b1;
    repeat (6) @(posedge clk);
    n_tests++;
    if (done_cnt != d0 || acc_cycs.size() != 0) begin
      n_fail++;
      $display("FAIL rstmid_no_done got dones=%0d pops=%0d exp 0 0", done_cnt - d0, acc_cycs.size());
    end
    clear_obs();
    drive_push(4, e);
    drive_push(-6, e);
    d0 = done_cnt;
    drive_start(2, s);
    wait_done(d0, ok);
    n_tests++;
    if (!ok || acc_cycs.size() != 2) begin
      n_fail++;
      $display("FAIL rstmid_next_job got done=%b n=%0d exp done=1 n=2", ok, acc_cycs.size());
    end
  endtask

`ifdef SFP_FEEDER_ABORT_EN
  task automatic test_abort();
    int e, s, d0;
    bit ok;
    clear_obs();
    drive_push(1, e);
    drive_push(-1, e);
    drive_push(2, e);
    drive_push(-2, e);
    d0 = done_cnt;
    drive_start(4, s);
    @(posedge clk); #1;
    abort_r  = 1'b1;
    in_valid = 1'b1;
    in_data  = 4'sd5;
    @(posedge clk); #1;
    abort_r  = 1'b0;
    in_valid = 1'b0;
    model.delete();
    n_tests++;
    if (busy !== 1'b0 || in_ready !== 1'b1 || acc !== 1'b0) begin
      n_fail++;
      $display("FAIL abort_state got busy=%b in_ready=%b acc=%b exp 0 1 0", busy, in_ready, acc);
    end
    repeat (6) @(posedge clk);
    n_tests++;
    if (done_cnt != d0 || acc_cycs.size() != 0) begin
      n_fail++;
      $display("FAIL abort_no_done got dones=%0d pops=%0d exp 0 0", done_cnt - d0, acc_cycs.size());
    end
    drive_push(3, e);
    drive_start(1, s);
    wait_done(d0, ok);
    n_tests++;
    if (!ok || acc_cycs.size() != 1) begin
      n_fail++;
      $display("FAIL abort_next_job got done=%b n=%0d exp done=1 n=1", ok, acc_cycs.size());
    end
  endtask
`endif

  initial begin
    test_reset();
    test_basic();
    test_stall();
    test_full();
    test_len0();
    test_reset_mid();
`ifdef SFP_FEEDER_ABORT_EN
    test_abort();
`endif
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog got no finish exp finish");
    $fatal(1);
  end
endmodule
